// File: rtl/dsram_port_arbiter.sv
// dsram_port_arbiter: shares the single-port data SRAM between the MEM stage
// (port 0, priority) and an aux master (port 1) with starvation and burst relief.
module dsram_port_arbiter #(
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [3:0]  m0_wen,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_stall,
    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic [3:0]  m1_wen,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    typedef enum logic [1:0] {
        NORM,
        FORCE1,
        BURST1
    } arbState_t;

    typedef struct packed {
        logic valid;
        logic port;
    } rdTag_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX - 1);
    localparam logic [2:0] STARVE_SAT = 3'(STARVE_MAX);
    localparam logic [3:0] BEAT_LAST  = 4'(BURST_MAX);

    arbState_t  state;
    arbState_t  stateNext;
    logic [2:0] starveCnt;
    logic [2:0] starveNext;
    logic [3:0] beatCnt;
    logic [3:0] beatNext;
    logic       m0Gnt;
    logic       m1Gnt;
    logic       m1Refused;
    rdTag_t     tagPipe [RD_LAT];
    rdTag_t     tagIn;
    rdTag_t     tagHead;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= NORM;
            starveCnt <= '0;
            beatCnt   <= '0;
        end else begin
            state     <= stateNext;
            starveCnt <= starveNext;
            beatCnt   <= beatNext;
        end
    end

    assign m1Refused = m1_req & ~m1Gnt;

    always_comb begin
        stateNext = state;
        beatNext  = '0;
        unique case (state)
            NORM: begin
                beatNext = (m1Gnt & m1_lock) ? 4'd1 : 4'd0;
                if (m1Gnt && m1_lock)
                    stateNext = BURST1;
                else if (m1Refused && starveCnt == STARVE_LIM)
                    stateNext = FORCE1;
            end
            FORCE1: begin
                beatNext = (m1Gnt & m1_lock) ? 4'd1 : 4'd0;
                if (!m1Gnt)
                    stateNext = NORM;
                else
                    stateNext = m1_lock ? BURST1 : NORM;
            end
            BURST1: begin
                beatNext = m1Gnt ? beatCnt + 4'd1 : 4'd0;
                if (!m1Gnt || beatCnt + 4'd1 == BEAT_LAST)
                    stateNext = NORM;
            end
            default: stateNext = NORM;
        endcase
    end

    // Starvation only counts unbroken runs of refused port 1 requests.
    always_comb begin
        starveNext = starveCnt;
        if (!m1_req || m1Gnt)
            starveNext = '0;
        else if (starveCnt < STARVE_SAT)
            starveNext = starveCnt + 3'd1;
    end

    always_comb begin
        m0Gnt = 1'b0;
        m1Gnt = 1'b0;
        if (!rst) begin
            unique case (state)
                NORM: begin
                    m0Gnt = m0_req;
                    m1Gnt = m1_req & ~m0_req;
                end
                FORCE1: m1Gnt = m1_req;
                BURST1: m1Gnt = m1_req & m1_lock & (beatCnt < BEAT_LAST);
                default: ;
            endcase
        end
    end

    always_comb begin
        m0_gnt     = m0Gnt;
        m1_gnt     = m1Gnt;
        m0_stall   = m0_req & ~m0Gnt & ~rst;
        sram_en    = m0Gnt | m1Gnt;
        sram_wen   = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (m0Gnt) begin
            sram_wen   = m0_wen;
            sram_addr  = m0_addr;
            sram_wdata = m0_wdata;
        end else if (m1Gnt) begin
            sram_wen   = m1_wen;
            sram_addr  = m1_addr;
            sram_wdata = m1_wdata;
        end
    end

    // Tag pipe is as deep as the SRAM read latency so the head lines up with sram_rdata.
    assign tagIn = '{valid: sram_en & ~(|sram_wen), port: m1Gnt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++)
                tagPipe[i] <= '0;
        end else begin
            tagPipe[0] <= tagIn;
            for (int i = 1; i < RD_LAT; i++)
                tagPipe[i] <= tagPipe[i-1];
        end
    end

    assign tagHead   = tagPipe[RD_LAT-1];
    assign m0_rvalid = tagHead.valid & ~tagHead.port;
    assign m1_rvalid = tagHead.valid & tagHead.port;
    assign m0_rdata  = m0_rvalid ? sram_rdata : '0;
    assign m1_rdata  = m1_rvalid ? sram_rdata : '0;

endmodule

// File: tb/tb_dsram_port_arbiter.sv
// tb_dsram_port_arbiter: directed stimulus with a grant/read-return scoreboard
// checked by a monitor on the falling edge.
module tb_dsram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req;
    logic [3:0]  m0_wen;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m0_stall;
    logic        m1_req;
    logic        m1_lock;
    logic [3:0]  m1_wen;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    typedef struct {
        logic [1:0]  gnt;
        logic        stall;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gntExp_t;

    typedef struct {
        logic [1:0]  rv;
        logic [31:0] data;
    } rdExp_t;

    gntExp_t     gntQ[$];
    rdExp_t      rdQ[$];
    int          nPass = 0;
    int          nTotal = 0;
    logic [31:0] mem [256];

    always #5 clk = ~clk;

    dsram_port_arbiter #(
        .RD_LAT(1),
        .STARVE_MAX(4),
        .BURST_MAX(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .m0_req(m0_req),
        .m0_wen(m0_wen),
        .m0_addr(m0_addr),
        .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata),
        .m0_stall(m0_stall),
        .m1_req(m1_req),
        .m1_lock(m1_lock),
        .m1_wen(m1_wen),
        .m1_addr(m1_addr),
        .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata),
        .sram_en(sram_en),
        .sram_wen(sram_wen),
        .sram_addr(sram_addr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    // SRAM model, one-cycle read latency; word i preloads to C0DE_iiii.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= {16'hC0DE, 8'(i), 8'(i)};
            sram_rdata <= '0;
        end else if (sram_en) begin
            if (sram_wen == 4'b0000)
                sram_rdata <= mem[sram_addr[9:2]];
            else
                for (int b = 0; b < 4; b++)
                    if (sram_wen[b])
                        mem[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
    end

    task automatic check(input string name, input logic [159:0] got,
                         input logic [159:0] exp);
        nTotal++;
        if (got === exp)
            nPass++;
        else
            $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    always @(negedge clk) begin : monitor
        gntExp_t g;
        rdExp_t  r;
        if (!rst) begin
            if (m0_gnt || m1_gnt) begin
                if (gntQ.size() == 0) begin
                    check("unexpected grant", 160'({m1_gnt, m0_gnt}), 160'(0));
                end else begin
                    g = gntQ.pop_front();
                    check("grant",
                          160'({m1_gnt, m0_gnt, m0_stall, sram_en,
                                sram_wen, sram_addr, sram_wdata}),
                          160'({g.gnt, g.stall, 1'b1, g.wen, g.addr, g.wdata}));
                end
            end
            if (m0_rvalid || m1_rvalid) begin
                if (rdQ.size() == 0) begin
                    check("unexpected rvalid", 160'({m1_rvalid, m0_rvalid}), 160'(0));
                end else begin
                    r = rdQ.pop_front();
                    check("read return",
                          160'({m1_rvalid, m0_rvalid, m1_rdata, m0_rdata}),
                          160'({r.rv, r.rv[1] ? r.data : 32'h0,
                                r.rv[0] ? r.data : 32'h0}));
                end
            end
        end
    end

    task automatic setM0(input logic r, input logic [3:0] w,
                         input logic [31:0] a, input logic [31:0] d);
        m0_req   = r;
        m0_wen   = w;
        m0_addr  = a;
        m0_wdata = d;
    endtask

    task automatic setM1(input logic r, input logic l, input logic [3:0] w,
                         input logic [31:0] a, input logic [31:0] d);
        m1_req   = r;
        m1_lock  = l;
        m1_wen   = w;
        m1_addr  = a;
        m1_wdata = d;
    endtask

    // One cycle: port = expected granted port (-1 none), rd = expected read data.
    task automatic cyc(input int port, input logic stall,
                       input logic [31:0] rd, input bit dropRd = 1'b0);
        gntExp_t g;
        rdExp_t  r;
        if (port >= 0) begin
            g.gnt   = (port == 1) ? 2'b10 : 2'b01;
            g.stall = stall;
            g.wen   = (port == 1) ? m1_wen : m0_wen;
            g.addr  = (port == 1) ? m1_addr : m0_addr;
            g.wdata = (port == 1) ? m1_wdata : m0_wdata;
            gntQ.push_back(g);
            if (g.wen == 4'b0000 && !dropRd) begin
                r.rv   = g.gnt;
                r.data = rd;
                rdQ.push_back(r);
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [159:0] allOut();
        return 160'({m0_gnt, m0_rvalid, m0_rdata, m0_stall, m1_gnt, m1_rvalid,
                     m1_rdata, sram_en, sram_wen, sram_addr, sram_wdata});
    endfunction

    initial begin
        rst = 1'b1;
        setM0(1'b1, 4'h0, 32'h100, 32'h0);
        setM1(1'b1, 1'b1, 4'h0, 32'h20, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset outputs", allOut(), 160'(0));
        setM0(1'b0, 4'h0, 32'h0, 32'h0);
        setM1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) cyc(-1, 1'b0, 32'h0);

        // single port 0 read
        setM0(1'b1, 4'h0, 32'h100, 32'h0);
        cyc(0, 1'b0, 32'hC0DE4040);
        setM0(1'b0, 4'h0, 32'h0, 32'h0);
        cyc(-1, 1'b0, 32'h0);

        // SWL-style partial store, then read back the merged word
        setM0(1'b1, 4'b0011, 32'h201, 32'h0000ABCD);
        cyc(0, 1'b0, 32'h0);
        setM0(1'b1, 4'h0, 32'h200, 32'h0);
        cyc(0, 1'b0, 32'hC0DEABCD);
        setM0(1'b0, 4'h0, 32'h0, 32'h0);
        cyc(-1, 1'b0, 32'h0);

        // starvation: port 1 forced ahead after four refusals
        setM0(1'b1, 4'h0, 32'h100, 32'h0);
        setM1(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        repeat (4) cyc(0, 1'b0, 32'hC0DE4040);
        cyc(1, 1'b1, 32'hC0DE0808);
        setM1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cyc(0, 1'b0, 32'hC0DE4040);
        setM0(1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) cyc(-1, 1'b0, 32'h0);

        // locked burst capped at eight beats
        setM0(1'b1, 4'h0, 32'h100, 32'h0);
        setM1(1'b1, 1'b1, 4'hF, 32'h300, 32'h12345678);
        repeat (4) cyc(0, 1'b0, 32'hC0DE4040);
        repeat (8) cyc(1, 1'b1, 32'h0);
        cyc(0, 1'b0, 32'hC0DE4040);
        setM0(1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) cyc(1, 1'b0, 32'h0);
        setM1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cyc(-1, 1'b0, 32'h0);
        setM1(1'b1, 1'b0, 4'h0, 32'h300, 32'h0);
        cyc(1, 1'b0, 32'h12345678);
        setM1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cyc(-1, 1'b0, 32'h0);

        // back-to-back reads alternating ports
        setM0(1'b1, 4'h0, 32'h10, 32'h0);
        cyc(0, 1'b0, 32'hC0DE0404);
        setM0(1'b0, 4'h0, 32'h0, 32'h0);
        setM1(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        cyc(1, 1'b0, 32'hC0DE0808);
        setM1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        setM0(1'b1, 4'h0, 32'h30, 32'h0);
        cyc(0, 1'b0, 32'hC0DE0C0C);
        setM0(1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) cyc(-1, 1'b0, 32'h0);

        // reset right after a granted read drops the return
        setM0(1'b1, 4'h0, 32'h10, 32'h0);
        cyc(0, 1'b0, 32'h0, 1'b1);
        rst = 1'b1;
        setM1(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        @(negedge clk);
        check("async reset outputs", allOut(), 160'(0));
        setM0(1'b0, 4'h0, 32'h0, 32'h0);
        setM1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) cyc(-1, 1'b0, 32'h0);

        check("grant queue drained", 160'(gntQ.size()), 160'(0));
        check("read queue drained", 160'(rdQ.size()), 160'(0));
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
